// File: rtl/cpu_selfcheck_pkg.sv
// Shared types for the CPU self-check harness.
//   state_t      : controller states (IDLE loads the table, RELEASE pulses the
//                  CPU reset, RUN compares writebacks, DONE publishes results)
//   entry_kind_t : what an expected-table entry describes
//   entry_t      : one expected event laid out at the default widths
//                  (32-bit data, 4-bit register index); the harness packs
//                  {kind, idx, data} in the same order for any width
//   FLAG_MSB/LSB : NZCV field inside the status word
package cpu_selfcheck_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        KIND_REG    = 1'b0,
        KIND_STATUS = 1'b1
    } entry_kind_t;

    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_IDX_W  = 4;

    typedef struct packed {
        entry_kind_t             kind;
        logic [ENTRY_IDX_W-1:0]  idx;
        logic [ENTRY_DATA_W-1:0] data;
    } entry_t;

    localparam int FLAG_MSB = 31;
    localparam int FLAG_LSB = 28;

endpackage

// File: rtl/cpu_selfcheck_harness_expect_table.sv
// Expected-event table: DEPTH x ENTRY_W memory, one write port and one
// synchronous read port, written so synthesis maps it onto block RAM.
// Ports:
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data captured on the rising edge
//   rd_addr : read address, rd_data holds mem[rd_addr] one cycle later
module expect_table #(
    parameter int ENTRY_W = 37,
    parameter int DEPTH   = 64,
    parameter int AW      = 6
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // No reset: block RAM has none, and contents are reloaded before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cpu_selfcheck_harness.sv
// On-chip self-check for integrated_cpu. Loads expected writeback events,
// releases the CPU from reset at cfg_start_pc, compares every register and
// status writeback in order, and reports pass/fail with first-failure capture.
// Ports:
//   cfg_start_pc            : start PC latched on run, driven on cpu_start_pc
//   ld_valid/ld_ready       : table load handshake; an entry {ld_kind, ld_idx,
//                             ld_data} transfers on a cycle where both are high
//   run                     : one-cycle start pulse, honoured only in IDLE
//   cpu_rst_n, cpu_start_pc : reset and start PC to the CPU
//   wb_*, st_*              : CPU register-file and status writes under test
//   busy, done, pass, timeout, error_count, fail_entry, fail_actual : results
//   dbg_state               : current controller state
module cpu_selfcheck_harness
    import cpu_selfcheck_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 4,
    parameter int PC_W      = 11,
    parameter int DEPTH     = 64,
    parameter int TIMEOUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PC_W-1:0]          cfg_start_pc,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic                     ld_kind,
    input  logic [REG_IDX_W-1:0]     ld_idx,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     run,
    output logic                     cpu_rst_n,
    output logic [PC_W-1:0]          cpu_start_pc,
    input  logic                     wb_en,
    input  logic [REG_IDX_W-1:0]     wb_idx,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     st_en,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [15:0]              error_count,
    output logic [$clog2(DEPTH)-1:0] fail_entry,
    output logic [DATA_W-1:0]        fail_actual,
    output state_t                   dbg_state
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + REG_IDX_W + DATA_W;
    localparam logic [AW:0] WP_FULL = (AW+1)'(DEPTH);

    state_t               state;
    logic [AW:0]          wp;
    logic [AW:0]          rp;
    logic                 reload;    // next accepted load restarts the table at 0
    logic [TIMEOUT_W-1:0] wd;

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;
    logic [ENTRY_W-1:0]   rd_entry;
    entry_kind_t          e_kind;
    logic [REG_IDX_W-1:0] e_idx;
    logic [DATA_W-1:0]    e_data;
    logic                 ev;
    logic                 sel_status;
    logic                 match;
    logic [DATA_W-1:0]    obs_data;
    logic [AW:0]          rp_inc;

    assign dbg_state = state;
    assign ld_ready  = (state == IDLE) && (reload || (wp != WP_FULL));
    // run takes priority over a load presented in the same cycle.
    assign wr_en     = ld_valid && ld_ready && !run;
    assign wr_addr   = reload ? '0 : wp[AW-1:0];

    // Read the entry for the next compare: rp+1 when this cycle consumes one,
    // otherwise keep re-reading rp. table[rp] is thus valid in every RUN cycle.
    assign rp_inc  = rp + 1'b1;
    assign rd_addr = ev ? rp_inc[AW-1:0] : rp[AW-1:0];

    expect_table #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({ld_kind, ld_idx, ld_data}),
        .rd_addr (rd_addr),
        .rd_data (rd_entry)
    );

    assign e_kind = entry_kind_t'(rd_entry[ENTRY_W-1]);
    assign e_idx  = rd_entry[DATA_W +: REG_IDX_W];
    assign e_data = rd_entry[DATA_W-1:0];

    // With both strobes high, the expected kind decides which one is the event.
    assign ev         = (state == RUN) && (wb_en || st_en);
    assign sel_status = st_en && (!wb_en || (e_kind == KIND_STATUS));
    assign obs_data   = sel_status ? st_data : wb_data;

    always_comb begin
        match = 1'b0;
        if (sel_status) begin
            match = (e_kind == KIND_STATUS) &&
                    (st_data[FLAG_MSB:FLAG_LSB] == e_data[FLAG_MSB:FLAG_LSB]);
        end else begin
            match = (e_kind == KIND_REG) && (wb_idx == e_idx) && (wb_data == e_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wp           <= '0;
            rp           <= '0;
            reload       <= 1'b0;
            wd           <= '0;
            cpu_rst_n    <= 1'b0;
            cpu_start_pc <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            error_count  <= '0;
            fail_entry   <= '0;
            fail_actual  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        cpu_start_pc <= cfg_start_pc;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                        error_count  <= '0;
                        fail_entry   <= '0;
                        fail_actual  <= '0;
                        rp           <= '0;
                        state        <= (wp == '0) ? DONE : RELEASE;
                    end else if (wr_en) begin
                        wp     <= reload ? (AW+1)'(1) : wp + 1'b1;
                        reload <= 1'b0;
                    end
                end
                RELEASE: begin
                    // cpu_rst_n was low for this whole cycle
                    cpu_rst_n <= 1'b1;
                    busy      <= 1'b1;
                    wd        <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (ev) begin
                        wd <= '0;
                        rp <= rp_inc;
                        if (!match) begin
                            if (error_count != 16'hFFFF) begin
                                error_count <= error_count + 16'd1;
                            end
                            // error_count never wraps back to zero, so zero
                            // means no earlier mismatch in this test
                            if (error_count == 16'd0) begin
                                fail_entry  <= rp[AW-1:0];
                                fail_actual <= obs_data;
                            end
                        end
                        if (rp_inc == wp) begin
                            busy      <= 1'b0;
                            cpu_rst_n <= 1'b0;
                            state     <= DONE;
                        end
                    end else if (wd == {TIMEOUT_W{1'b1}}) begin
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    pass   <= (error_count == 16'd0) && !timeout;
                    reload <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_selfcheck_harness.sv
module tb_cpu_selfcheck_harness;
  import cpu_selfcheck_pkg::*;

  localparam int DEPTH     = 4;
  localparam int TIMEOUT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cfg_start_pc = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_kind = 1'b0;
  logic [3:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;
  logic        run = 1'b0;
  logic        cpu_rst_n;
  logic [10:0] cpu_start_pc;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_idx = '0;
  logic [31:0] wb_data = '0;
  logic        st_en = 1'b0;
  logic [31:0] st_data = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] error_count;
  logic [1:0]  fail_entry;
  logic [31:0] fail_actual;
  state_t      dbg_state;

  cpu_selfcheck_harness #(
    .DATA_W(32), .REG_IDX_W(4), .PC_W(11), .DEPTH(DEPTH), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start_pc(cfg_start_pc),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_kind(ld_kind), .ld_idx(ld_idx),
    .ld_data(ld_data), .run(run), .cpu_rst_n(cpu_rst_n), .cpu_start_pc(cpu_start_pc),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .st_en(st_en), .st_data(st_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .error_count(error_count),
    .fail_entry(fail_entry), .fail_actual(fail_actual), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  // ---------------- records ----------------
  typedef struct packed {
    logic [2:0] tc;
    entry_t     e;
  } ld_rec_t;

  typedef struct packed {
    logic [2:0]  tc;
    logic        wb;
    logic        st;
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic        match;
  } ev_rec_t;

  typedef struct packed {
    logic        pass;
    logic [15:0] ec;
    logic [1:0]  fe;
    logic [31:0] fa;
  } res_t;

  ld_rec_t ld_tab[16];
  ev_rec_t ev_tab[16];
  res_t    res_tab[5];
  int      n_ld = 0;
  int      n_ev = 0;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] ec_model;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic ld_rec_t mk_ld(input int tc, input entry_kind_t k, input int idx, input logic [31:0] d);
    ld_rec_t r;
    r.tc = 3'(tc);
    r.e.kind = k;
    r.e.idx = 4'(idx);
    r.e.data = d;
    return r;
  endfunction

  function automatic ev_rec_t mk_ev(input int tc, input logic wb, input logic st, input int idx,
                                    input logic [31:0] wd, input logic [31:0] sd, input logic m);
    ev_rec_t r;
    r.tc = 3'(tc);
    r.wb = wb;
    r.st = st;
    r.idx = 4'(idx);
    r.wdata = wd;
    r.sdata = sd;
    r.match = m;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load(input entry_t e);
    ld_valid = 1'b1;
    ld_kind  = e.kind;
    ld_idx   = e.idx;
    ld_data  = e.data;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic do_run(input logic expect_release);
    logic [10:0] pc;
    pc = 11'($urandom_range(0, 2047));
    cfg_start_pc = pc;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    chk("start_pc", 32'(cpu_start_pc), 32'(pc));
    chk("release_rst_low", 32'(cpu_rst_n), 32'd0);
    if (expect_release) begin
      @(posedge clk); #1;
      chk("run_rst_high", 32'(cpu_rst_n), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_ld_ready", 32'(ld_ready), 32'd0);
    end
  endtask

  // One event; the expected error_count is queued now and compared when the
  // registered compare result appears after the next edge.
  task automatic apply_ev(input ev_rec_t v, input logic with_run);
    wb_en   = v.wb;
    st_en   = v.st;
    wb_idx  = v.wb ? v.idx : 4'($urandom_range(0, 15));
    wb_data = v.wb ? v.wdata : $urandom;
    st_data = v.st ? v.sdata : $urandom;
    run     = with_run;
    if (!v.match) ec_model = ec_model + 16'd1;
    exp_q.push_back(ec_model);
    @(posedge clk); #1;
    wb_en = 1'b0;
    st_en = 1'b0;
    run   = 1'b0;
    chk("ec_step", 32'(error_count), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_ld_ready"}, 32'(ld_ready), 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    // table: loads, events, expected final result per case
    ld_tab[n_ld++] = mk_ld(0, KIND_REG, 0, 32'd1);
    ld_tab[n_ld++] = mk_ld(0, KIND_REG, 1, 32'd2);
    ld_tab[n_ld++] = mk_ld(0, KIND_STATUS, 0, 32'h8000_0000);
    ld_tab[n_ld++] = mk_ld(2, KIND_STATUS, 0, 32'h4000_0000);
    ld_tab[n_ld++] = mk_ld(2, KIND_REG, 2, 32'd5);
    ld_tab[n_ld++] = mk_ld(3, KIND_REG, 3, 32'hAA);
    ld_tab[n_ld++] = mk_ld(3, KIND_STATUS, 0, 32'h2000_0000);
    ld_tab[n_ld++] = mk_ld(4, KIND_REG, 4, 32'h1234_5678);
    ld_tab[n_ld++] = mk_ld(4, KIND_STATUS, 0, 32'hF000_0000);

    ev_tab[n_ev++] = mk_ev(0, 1, 0, 0, 32'd1, 0, 1);
    ev_tab[n_ev++] = mk_ev(0, 1, 0, 1, 32'd2, 0, 1);
    ev_tab[n_ev++] = mk_ev(0, 0, 1, 0, 0, 32'h8000_0000, 1);
    // case 1 reruns the case 0 table
    ev_tab[n_ev++] = mk_ev(1, 1, 0, 0, 32'd1, 0, 1);
    ev_tab[n_ev++] = mk_ev(1, 1, 0, 1, 32'd3, 0, 0);
    ev_tab[n_ev++] = mk_ev(1, 0, 1, 0, 0, 32'h8000_0000, 1);
    // both strobes, status entry: only NZCV compared
    ev_tab[n_ev++] = mk_ev(2, 1, 1, 7, 32'd9, 32'h4123_4567, 1);
    ev_tab[n_ev++] = mk_ev(2, 1, 0, 2, 32'd5, 0, 1);
    // wrong kind both ways
    ev_tab[n_ev++] = mk_ev(3, 0, 1, 0, 0, 32'h2000_0000, 0);
    ev_tab[n_ev++] = mk_ev(3, 1, 0, 3, 32'hAA, 0, 0);
    // both strobes, register entry: status value ignored
    ev_tab[n_ev++] = mk_ev(4, 1, 1, 4, 32'h1234_5678, 32'h0000_0000, 1);
    ev_tab[n_ev++] = mk_ev(4, 0, 1, 0, 0, 32'hF0FF_FFFF, 1);

    res_tab[0] = '{pass: 1'b1, ec: 16'd0, fe: 2'd0, fa: 32'd0};
    res_tab[1] = '{pass: 1'b0, ec: 16'd1, fe: 2'd1, fa: 32'd3};
    res_tab[2] = '{pass: 1'b1, ec: 16'd0, fe: 2'd0, fa: 32'd0};
    res_tab[3] = '{pass: 1'b0, ec: 16'd2, fe: 2'd0, fa: 32'h2000_0000};
    res_tab[4] = '{pass: 1'b1, ec: 16'd0, fe: 2'd0, fa: 32'd0};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_start_pc", 32'(cpu_start_pc), 32'd0);
    chk("rst_flags", {28'd0, busy, done, pass, timeout}, 32'd0);
    chk("rst_ec", 32'(error_count), 32'd0);
    chk("rst_fail", fail_actual | 32'(fail_entry), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // run with an empty table: straight to DONE, CPU kept in reset
    do_run(1'b0);
    wait_done("empty", 10);
    chk("empty_pass", 32'(pass), 32'd1);

    // table-driven cases
    for (int c = 0; c < 5; c++) begin
      int k;
      ec_model = '0;
      for (int i = 0; i < n_ld; i++) if (ld_tab[i].tc == 3'(c)) load(ld_tab[i].e);
      do_run(1'b1);
      k = 0;
      for (int i = 0; i < n_ev; i++) begin
        if (ev_tab[i].tc == 3'(c)) begin
          // a run pulse during RUN must be ignored
          apply_ev(ev_tab[i], k == 1);
          k++;
        end
      end
      wait_done($sformatf("case%0d", c), 20);
      chk($sformatf("case%0d_pass", c), 32'(pass), 32'(res_tab[c].pass));
      chk($sformatf("case%0d_ec", c), 32'(error_count), 32'(res_tab[c].ec));
      chk($sformatf("case%0d_fe", c), 32'(fail_entry), 32'(res_tab[c].fe));
      chk($sformatf("case%0d_fa", c), fail_actual, res_tab[c].fa);
      chk($sformatf("case%0d_timeout", c), 32'(timeout), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("case%0d_done_sticky", c), 32'(done), 32'd1);
    end

    // full table: 4 loads accepted, fifth dropped, run consumes exactly 4
    begin
      entry_t e;
      ec_model = '0;
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("full_ld_ready%0d", i), 32'(ld_ready), (i < 4) ? 32'd1 : 32'd0);
        e.kind = KIND_REG;
        e.idx  = 4'(i % 4);
        e.data = (i < 4) ? 32'(i + 10) : 32'hDEAD_BEEF;
        load(e);
      end
      do_run(1'b1);
      for (int i = 0; i < 3; i++) apply_ev(mk_ev(0, 1, 0, i, 32'(i + 10), 0, 1), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("full_not_done_after3", 32'(done), 32'd0);
      chk("full_busy_after3", 32'(busy), 32'd1);
      apply_ev(mk_ev(0, 1, 0, 3, 32'd13, 0, 1), 1'b0);
      wait_done("full", 10);
      chk("full_pass", 32'(pass), 32'd1);
    end

    // watchdog: two entries, one event, then silence
    begin
      entry_t e;
      int n;
      ec_model = '0;
      e.kind = KIND_REG; e.idx = 4'd5; e.data = 32'd7; load(e);
      e.kind = KIND_REG; e.idx = 4'd6; e.data = 32'd8; load(e);
      do_run(1'b1);
      apply_ev(mk_ev(0, 1, 0, 5, 32'd7, 0, 1), 1'b0);
      n = 0;
      while (timeout !== 1'b1 && n < 400) begin
        @(posedge clk); #1;
        n++;
        if (n == 200) chk("wd_not_early", 32'(timeout), 32'd0);
      end
      chk("wd_timeout", 32'(timeout), 32'd1);
      wait_done("wd", 10);
      chk("wd_pass", 32'(pass), 32'd0);
      chk("wd_ec", 32'(error_count), 32'd0);
    end

    // reset in the middle of RUN, then reload and rerun
    begin
      entry_t e;
      ec_model = '0;
      e.kind = KIND_REG; e.idx = 4'd1; e.data = 32'h11; load(e);
      e.kind = KIND_REG; e.idx = 4'd2; e.data = 32'h22; load(e);
      do_run(1'b1);
      apply_ev(mk_ev(0, 1, 0, 2, 32'h99, 0, 0), 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("mid_rst_start_pc", 32'(cpu_start_pc), 32'd0);
      chk("mid_rst_flags", {28'd0, busy, done, pass, timeout}, 32'd0);
      chk("mid_rst_ec", 32'(error_count), 32'd0);
      chk("mid_rst_fail", fail_actual | 32'(fail_entry), 32'd0);
      chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      ec_model = '0;
      e.kind = KIND_REG; e.idx = 4'd1; e.data = 32'h11; load(e);
      e.kind = KIND_STATUS; e.idx = 4'd0; e.data = 32'h6000_0000; load(e);
      do_run(1'b1);
      apply_ev(mk_ev(0, 1, 0, 1, 32'h11, 0, 1), 1'b0);
      apply_ev(mk_ev(0, 0, 1, 0, 0, 32'h6ABC_0000, 1), 1'b0);
      wait_done("after_rst", 10);
      chk("after_rst_pass", 32'(pass), 32'd1);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
